// File: rtl/kernel_tap_mac.sv
// kernel_tap_mac
// 3x3 convolution tap sequencer with a saturating multiply-accumulate stage.
// The nine kernel taps are walked in raster order. For each tap the block drives
// the select code to an external weight mux and takes the weight back in the same
// cycle. It multiplies that weight by the streamed pixel and adds the product into
// a sticky-saturating accumulator. Each start produces one window sum.
module kernel_tap_mac #(
    parameter int PIX_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [3:0]       select,
    input  logic [3:0]       k_w,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int PROD_W = PIX_W + 4;
    localparam int SUM_W  = ACC_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         tap_idx_r;
    logic [ACC_W-1:0]   acc_r;
    logic               sat_r;

    logic [PROD_W-1:0]  prod_s;
    logic [SUM_W-1:0]   sum_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic               sat_next_s;
    logic               accept_s;

    // Raster-order tap index to weight-mux select code; unused indices select nothing.
    function automatic logic [3:0] tap_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'b0001;
            4'd1:    code = 4'b0111;
            4'd2:    code = 4'b0010;
            4'd3:    code = 4'b0110;
            4'd4:    code = 4'b1111;
            4'd5:    code = 4'b0101;
            4'd6:    code = 4'b0011;
            4'd7:    code = 4'b1000;
            4'd8:    code = 4'b0100;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // Product, one-bit-wider sum and the clamped next accumulator value.
    always_comb begin
        prod_s   = PROD_W'(pix_data) * PROD_W'(k_w);
        sum_s    = {1'b0, acc_r} + SUM_W'(prod_s);
        accept_s = pix_valid & pix_ready;
        if (sum_s[ACC_W]) begin
            acc_next_s = {ACC_W{1'b1}};
            sat_next_s = 1'b1;
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
            sat_next_s = sat_r;
        end
    end

    // Sequencer FSM with all outputs registered; flush overrides every handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            tap_idx_r <= 4'd0;
            acc_r     <= {ACC_W{1'b0}};
            sat_r     <= 1'b0;
            acc_out   <= {ACC_W{1'b0}};
            sat_out   <= 1'b0;
            out_valid <= 1'b0;
            pix_ready <= 1'b0;
            select    <= 4'b0000;
            busy      <= 1'b0;
        end else if (flush) begin
            state_r   <= ST_IDLE;
            tap_idx_r <= 4'd0;
            acc_r     <= {ACC_W{1'b0}};
            sat_r     <= 1'b0;
            out_valid <= 1'b0;
            pix_ready <= 1'b0;
            select    <= 4'b0000;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_TAP;
                        tap_idx_r <= 4'd0;
                        acc_r     <= {ACC_W{1'b0}};
                        sat_r     <= 1'b0;
                        pix_ready <= 1'b1;
                        select    <= tap_code(4'd0);
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_TAP: begin
                    if (accept_s) begin
                        acc_r <= acc_next_s;
                        sat_r <= sat_next_s;
                        if (tap_idx_r == 4'd8) begin
                            state_r   <= ST_DONE;
                            tap_idx_r <= 4'd0;
                            acc_out   <= acc_next_s;
                            sat_out   <= sat_next_s;
                            out_valid <= 1'b1;
                            pix_ready <= 1'b0;
                            select    <= 4'b0000;
                        end else begin
                            tap_idx_r <= tap_idx_r + 4'd1;
                            select    <= tap_code(tap_idx_r + 4'd1);
                        end
                    end else begin
                        state_r <= ST_TAP;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state_r   <= ST_TAP;
                            tap_idx_r <= 4'd0;
                            acc_r     <= {ACC_W{1'b0}};
                            sat_r     <= 1'b0;
                            pix_ready <= 1'b1;
                            select    <= tap_code(4'd0);
                            busy      <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    tap_idx_r <= 4'd0;
                    acc_r     <= {ACC_W{1'b0}};
                    sat_r     <= 1'b0;
                    out_valid <= 1'b0;
                    pix_ready <= 1'b0;
                    select    <= 4'b0000;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_tap_mac.sv
// Testbench for kernel_tap_mac: two instances (16-bit and 12-bit accumulators)
// share stimulus; a window-level model (unbounded sum, clamped at compare time)
// predicts outputs every cycle, and literal values pin the model.
`timescale 1ns/1ps
module tb_kernel_tap_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, pix_valid, out_ready;
    logic [7:0]  pix_data;

    logic        pr_a, sat_a, ov_a, busy_a;
    logic [3:0]  sel_a, kw_a;
    logic [15:0] acc_a;
    logic        pr_b, sat_b, ov_b, busy_b;
    logic [3:0]  sel_b, kw_b;
    logic [11:0] acc_b;

    int tests = 0;
    int fails = 0;

    int codes [9] = '{1, 7, 2, 6, 15, 5, 3, 8, 4};
    int w_tab [9];
    int pix_tab [9];

    // model state
    int     m_phase;   // 0 idle, 1 taps, 2 result
    int     m_tap;
    longint m_sum;
    longint m_res;

    always #5 clk = ~clk;

    kernel_tap_mac #(.PIX_W(8), .ACC_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pr_a),
        .select(sel_a), .k_w(kw_a), .acc_out(acc_a), .sat_out(sat_a),
        .out_valid(ov_a), .out_ready(out_ready), .busy(busy_a)
    );

    kernel_tap_mac #(.PIX_W(8), .ACC_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pr_b),
        .select(sel_b), .k_w(kw_b), .acc_out(acc_b), .sat_out(sat_b),
        .out_valid(ov_b), .out_ready(out_ready), .busy(busy_b)
    );

    // weight mux model: select code -> weight of that tap, 0 for unknown codes
    always_comb begin
        kw_a = 4'd0;
        kw_b = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (int'(sel_a) == codes[i]) kw_a = 4'(w_tab[i]);
            if (int'(sel_b) == codes[i]) kw_b = 4'(w_tab[i]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // window-level model: tracks phase, taps consumed and the true (unclamped) sum
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_tap = 0; m_sum = 0; m_res = 0;
        end else if (flush) begin
            m_phase = 0; m_tap = 0; m_sum = 0;
        end else if (m_phase == 0) begin
            if (start) begin m_phase = 1; m_tap = 0; m_sum = 0; end
        end else if (m_phase == 1) begin
            if (pix_valid) begin
                m_sum = m_sum + longint'(pix_data) * longint'(w_tab[m_tap]);
                if (m_tap == 8) begin m_phase = 2; m_res = m_sum; end
                else m_tap = m_tap + 1;
            end
        end else begin
            if (out_ready) begin
                if (start) begin m_phase = 1; m_tap = 0; m_sum = 0; end
                else m_phase = 0;
            end
        end
    end

    task automatic cmp_dut(input string tag, input logic pr, input logic [3:0] sel,
                           input logic bz, input logic ov, input logic [15:0] acc,
                           input logic st, input longint maxv);
        int exp_sel;
        exp_sel = (m_phase == 1) ? codes[m_tap] : 0;
        chk({tag, "_pix_ready"}, 32'(pr), 32'(m_phase == 1));
        chk({tag, "_select"}, 32'(sel), 32'(exp_sel));
        chk({tag, "_busy"}, 32'(bz), 32'(m_phase != 0));
        chk({tag, "_out_valid"}, 32'(ov), 32'(m_phase == 2));
        if (m_phase == 2) begin
            chk({tag, "_acc_out"}, 32'(acc), 32'((m_res > maxv) ? maxv : m_res));
            chk({tag, "_sat_out"}, 32'(st), 32'(m_res > maxv));
        end
    endtask

    // per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            cmp_dut("a", pr_a, sel_a, busy_a, ov_a, acc_a, sat_a, 64'd65535);
            cmp_dut("b", pr_b, sel_b, busy_b, ov_b, {4'd0, acc_b}, sat_b, 64'd4095);
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic set_all(input int w, input int p);
        for (int i = 0; i < 9; i++) begin w_tab[i] = w; pix_tab[i] = p; end
    endtask

    task automatic start_window();
        start = 1'b1; step(); start = 1'b0;
    endtask

    // present n pixels starting at tap 0; optional stall pattern; optional literal select pin
    task automatic feed(input int n, input bit gaps, input bit pin_sel);
        int i = 0;
        int k = 0;
        while (i < n && k < 100) begin
            pix_valid = gaps ? ((k % 3) != 1) : 1'b1;
            pix_data  = 8'(pix_tab[i]);
            @(negedge clk);
            if (pin_sel) chk("select_pin", 32'(sel_a), 32'(codes[i]));
            @(posedge clk); #2;
            if (pix_valid) i++;
            k++;
        end
        pix_valid = 1'b0;
    endtask

    task automatic ack();
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pix_ready"}, 32'(pr_a | pr_b), 32'd0);
        chk({tag, "_select"}, 32'({sel_a, sel_b}), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a | busy_b), 32'd0);
        chk({tag, "_out_valid"}, 32'(ov_a | ov_b), 32'd0);
        chk({tag, "_acc_out"}, 32'({acc_a, acc_b}), 32'd0);
        chk({tag, "_sat_out"}, 32'(sat_a | sat_b), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; pix_valid = 1'b0;
        pix_data = 8'd0; out_ready = 1'b0;
        set_all(1, 0);
        #3;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step();

        // 1: all weights 1, pixels 10, no stalls; select order pinned
        set_all(1, 10);
        start_window();
        feed(9, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_out_valid", 32'(ov_a), 32'd1);
        chk("t1_acc", 32'(acc_a), 32'd90);
        chk("t1_sat", 32'(sat_a), 32'd0);
        @(posedge clk); #2;
        ack();

        // 2: per-tap weights 1..7,0,7, pixels 1..9, stalls
        for (int i = 0; i < 9; i++) pix_tab[i] = i + 1;
        w_tab = '{1, 2, 3, 4, 5, 6, 7, 0, 7};
        start_window();
        feed(9, 1'b1, 1'b1);
        @(negedge clk);
        chk("t2_acc", 32'(acc_a), 32'd203);
        chk("t2_acc12", 32'(acc_b), 32'd203);
        @(posedge clk); #2;
        ack();

        // 3: saturation in the 12-bit instance, then a clean zero window
        set_all(7, 255);
        start_window();
        feed(9, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_acc16", 32'(acc_a), 32'd16065);
        chk("t3_sat16", 32'(sat_a), 32'd0);
        chk("t3_acc12", 32'(acc_b), 32'd4095);
        chk("t3_sat12", 32'(sat_b), 32'd1);
        @(posedge clk); #2;
        ack();
        set_all(7, 0);
        start_window();
        feed(9, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3b_acc12", 32'(acc_b), 32'd0);
        chk("t3b_sat12", 32'(sat_b), 32'd0);
        @(posedge clk); #2;
        ack();

        // 4: back-pressure in DONE, then handshake with start
        set_all(1, 10);
        start_window();
        feed(9, 1'b0, 1'b0);
        pix_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_acc", 32'(acc_a), 32'd90);
            chk("t4_hold_ready", 32'(pr_a), 32'd0);
            @(posedge clk); #2;
        end
        pix_valid = 1'b0;
        out_ready = 1'b1; start = 1'b1; step(); out_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t4_restart_sel", 32'(sel_a), 32'd1);
        chk("t4_restart_ready", 32'(pr_a), 32'd1);
        chk("t4_restart_valid", 32'(ov_a), 32'd0);
        @(posedge clk); #2;
        feed(9, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_acc", 32'(acc_a), 32'd90);
        @(posedge clk); #2;
        ack();

        // 5: flush after 4 pixels, then a window of 2s
        set_all(1, 2);
        start_window();
        feed(4, 1'b0, 1'b0);
        flush = 1'b1; step(); flush = 1'b0;
        @(negedge clk);
        chk("t5_flush_busy", 32'(busy_a), 32'd0);
        chk("t5_flush_valid", 32'(ov_a), 32'd0);
        @(posedge clk); #2;
        start_window();
        feed(9, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_acc", 32'(acc_a), 32'd18);
        @(posedge clk); #2;
        ack();

        // 6: asynchronous reset between edges mid-window, then a full window
        set_all(1, 3);
        start_window();
        feed(5, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1 chk_reset_outputs("t6_async");
        @(posedge clk); #2 rst = 1'b0;
        step();
        start_window();
        feed(9, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_acc", 32'(acc_a), 32'd27);
        @(posedge clk); #2;
        ack();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
